// File: rtl/neuron_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : neuron_pkg                                                 |
// | Brief   : Q4.12 constants and MAC state encoding shared by the       |
// |           neuron datapath (MAC and sigmoid stages).                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package neuron_pkg;

  localparam int          DATA_W    = 16;
  localparam int          FRAC_BITS = 12;
  localparam logic [15:0] Q_ONE     = 16'h1000;
  localparam logic [15:0] Q_MAX     = 16'h7FFF;
  localparam logic [15:0] Q_MIN     = 16'h8000;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/q_shift_sat.sv
// +----------------------------------------------------------------------+
// | Module  : q_shift_sat                                                |
// | Brief   : Floors a Q.24 accumulator to Q4.12; clamps when            |
// |           NEURON_MAC_SAT_EN is defined, otherwise truncates.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module q_shift_sat
  import neuron_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic        [DATA_W-1:0] q_out,
  output logic                     sat_out
);

  logic signed [ACC_W-1:0] w_shifted;

  // Arithmetic shift rounds toward negative infinity.
  assign w_shifted = acc_in >>> FRAC_BITS;

`ifdef NEURON_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] c_hi = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
  localparam logic signed [ACC_W-1:0] c_lo = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};

  always_comb begin
    q_out   = w_shifted[DATA_W-1:0];
    sat_out = 1'b0;
    if (w_shifted > c_hi) begin
      q_out   = Q_MAX;
      sat_out = 1'b1;
    end else if (w_shifted < c_lo) begin
      q_out   = Q_MIN;
      sat_out = 1'b1;
    end
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_shifted[ACC_W-1:DATA_W];
  assign q_out       = w_shifted[DATA_W-1:0];
  assign sat_out     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/neuron_mac.sv
// +----------------------------------------------------------------------+
// | Module  : neuron_mac                                                 |
// | Brief   : Streaming Q4.12 multiply-accumulate with bias; holds one   |
// |           result until accepted. Option macro: NEURON_MAC_SAT_EN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module neuron_mac
  import neuron_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_x,
  input  logic [15:0]       in_w,
  input  logic              in_last,
  input  logic [15:0]       bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_out_valid;
  logic [15:0]             r_out_data;
  logic [CNT_W-1:0]        r_out_count;
  logic                    r_out_sat;

  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic signed [ACC_W-1:0] w_acc_total;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic [DATA_W-1:0]       w_q;
  logic                    w_sat;
  logic                    w_accept;

  assign w_prod      = $signed(in_x) * $signed(in_w);
  assign w_prod_ext  = {{(ACC_W-32){w_prod[31]}}, w_prod};
  // Bias is Q4.12; moving it up 12 bits aligns it with the Q.24 products.
  assign w_bias_ext  = {{(ACC_W-DATA_W-FRAC_BITS){bias[15]}}, bias, {FRAC_BITS{1'b0}}};
  assign w_acc_sum   = r_acc + w_prod_ext;
  assign w_acc_total = w_acc_sum + w_bias_ext;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_accept    = in_valid && (r_state == ACCUM);

  q_shift_sat #(
    .ACC_W (ACC_W)
  ) u_q_shift_sat (
    .acc_in  (w_acc_total),
    .q_out   (w_q),
    .sat_out (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_sum;
            r_cnt <= w_cnt_inc;
            if (in_last) begin
              r_out_data  <= w_q;
              r_out_sat   <= w_sat;
              r_out_count <= w_cnt_inc;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac.sv
// +----------------------------------------------------------------------+
// | Module  : tb_neuron_mac                                              |
// | Brief   : Directed self-checking bench for neuron_mac.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_w = '0;
  logic        in_last = 1'b0;
  logic [15:0] bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        out_sat;

  int n_total = 0;
  int n_bad   = 0;

  neuron_mac #(
    .ACC_W (40),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives n beats (last on the final one), checks the held result, then handshakes it away.
  task automatic run_vec(input string tag, input int n, input logic [15:0] x, input logic [15:0] w,
                         input logic [15:0] b, input logic [15:0] exp_d, input logic [7:0] exp_c,
                         input logic exp_s);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_x     = x;
      in_w     = w;
      in_last  = (i == n - 1);
      bias     = b;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(exp_d));
    check({tag, "_count"}, 32'(out_count), 32'(exp_c));
    check({tag, "_sat"},   32'(out_sat),   32'(exp_s));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_sat",   32'(out_sat),   32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);

    run_vec("one",   1, 16'h1000, 16'h1000, 16'h0000, 16'h1000, 8'd1, 1'b0);
    run_vec("three", 3, 16'h0800, 16'h2000, 16'hF000, 16'h2000, 8'd3, 1'b0);
`ifdef NEURON_MAC_SAT_EN
    run_vec("big",   4, 16'h7000, 16'h7000, 16'h0000, 16'h7FFF, 8'd4, 1'b1);
    run_vec("neg",   4, 16'h7000, 16'h9000, 16'h0000, 16'h8000, 8'd4, 1'b1);
`else
    run_vec("big",   4, 16'h7000, 16'h7000, 16'h0000, 16'h4000, 8'd4, 1'b0);
    run_vec("neg",   4, 16'h7000, 16'h9000, 16'h0000, 16'hC000, 8'd4, 1'b0);
`endif
    run_vec("floor", 1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 8'd1, 1'b0);
    run_vec("half",  1, 16'hF000, 16'h0800, 16'h0000, 16'hF800, 8'd1, 1'b0);
    run_vec("wrap",  256, 16'h1000, 16'h0010, 16'h0000, 16'h1000, 8'd0, 1'b0);

    // Back-pressure: result pending while the source keeps offering beats.
    in_valid = 1'b1; in_x = 16'h0800; in_w = 16'h1000; in_last = 1'b1; bias = 16'h0000;
    @(posedge clk);
    #1;
    check("bp_valid0", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_ready",  32'(in_ready),  32'd0);
      check("bp_data",   32'(out_data),  32'h0800);
      check("bp_count",  32'(out_count), 32'd1);
      check("bp_valid",  32'(out_valid), 32'd1);
    end
    in_x = 16'h1000; in_w = 16'h1000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_drop",  32'(out_valid), 32'd0);
    check("bp_rdy1",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_next_data",  32'(out_data),  32'h1000);
    check("bp_next_count", 32'(out_count), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Partial vector discarded by reset.
    in_valid = 1'b1; in_x = 16'h4000; in_w = 16'h4000; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    run_vec("after_rst", 1, 16'h1000, 16'h1000, 16'h0000, 16'h1000, 8'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 The block SHALL have parameter ACC_W, default 40, giving the accumulator width in bits (signed, Q16.24).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the term-counter width in bits.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 in_x  input  16  signed Q4.12 activation.
REQ-009 in_w  input  16  signed Q4.12 weight.
REQ-010 in_last  input  1  final beat of the current vector.
REQ-011 bias  input  16  signed Q4.12 bias, sampled with the last beat.
REQ-012 out_valid  output  1  result valid; feeds the sigmoid stage.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  16  signed Q4.12 pre-activation sum.
REQ-015 out_count  output  CNT_W  number of beats in the vector, modulo 2^CNT_W.
REQ-016 out_sat  output  1  result was clamped.

Function
REQ-017 A beat SHALL be accepted on any rising edge with in_valid=1 and in_ready=1.
REQ-018 The block SHALL implement states ACCUM and HOLD; in_ready SHALL be 1 in ACCUM and 0 in HOLD.
REQ-019 On each accepted beat, the block SHALL add the full 32-bit signed product in_x*in_w (Q8.24), sign-extended to ACC_W, to the accumulator, and SHALL increment the term counter.
REQ-020 On an accepted beat with in_last=1, the block SHALL compute acc_total = acc + product + (bias sign-extended, <<12), SHALL latch the result, and SHALL enter HOLD.
REQ-021 out_valid SHALL assert on the edge following acceptance of the last beat (latency 1 cycle) and SHALL remain 1 in HOLD.
REQ-022 The result SHALL be acc_total arithmetically shifted right by 12, which is a floor toward negative infinity.
REQ-023 out_data, out_count and out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 On the edge where out_valid=1 and out_ready=1, the block SHALL clear the accumulator and counter, deassert out_valid, and return to ACCUM; no new beat SHALL be accepted on that same edge.
REQ-025 A one-beat vector (in_last on the first beat) SHALL be legal.
REQ-026 The counter SHALL wrap silently at 2^CNT_W.
REQ-027 Accumulator overflow beyond ACC_W SHALL wrap; ACC_W=40 covers at least 256 maximum-magnitude terms.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL set state=ACCUM, accumulator=0, counter=0, out_valid=0, out_data=0x0000, out_count=0 and out_sat=0.
REQ-029 A reset during a partial vector or during HOLD SHALL discard that vector; the next accepted beat SHALL start a fresh vector.

Configuration
REQ-030 With NEURON_MAC_SAT_EN defined, a shifted result above 32767 SHALL give out_data=0x7FFF, a result below -32768 SHALL give out_data=0x8000, and out_sat SHALL be set to 1 for that result.
REQ-031 Without NEURON_MAC_SAT_EN, out_data SHALL be the low 16 bits of the shifted result and out_sat SHALL be tied to 0.

Structure
REQ-032 Package neuron_pkg SHALL hold DATA_W=16, FRAC_BITS=12, Q_ONE=16'h1000, Q_MAX=16'h7FFF, Q_MIN=16'h8000 and the state enum {ACCUM, HOLD}; the sigmoid stage SHALL share these constants.
REQ-033 The shift/saturate logic SHALL be one combinational sub-module, q_shift_sat, parameterised by ACC_W.

Verification
REQ-034 One beat x=0x1000, w=0x1000, last, bias=0 -> one cycle later out_valid=1, out_data=0x1000, out_count=1, out_sat=0.
REQ-035 Three beats x=0x0800, w=0x2000, bias=0xF000 -> out_data=0x2000, out_count=3.
REQ-036 Four beats x=0x7000, w=0x7000, bias=0 -> with NEURON_MAC_SAT_EN: out_data=0x7FFF, out_sat=1; without: out_data=0x4000, out_sat=0.
REQ-037 One beat x=0xFFFF, w=0x0001, last, bias=0 -> out_data=0xFFFF (floor); one beat x=0xF000, w=0x0800 -> out_data=0xF800.
REQ-038 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, in_ready=0, no beats counted; after the handshake, the next vector x=0x1000, w=0x1000 gives out_data=0x1000 with no carry-over.
REQ-039 Two beats accepted, then rst pulsed for 1 cycle, then x=0x1000, w=0x1000, last -> out_data=0x1000, out_count=1.
